// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared types and constants for the UART program loader
package uart_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_CSUM
  } state_t;

  localparam logic [7:0] CMD_WRITE    = 8'h01;
  localparam logic [7:0] CMD_RUN      = 8'h02;
  localparam logic [7:0] CMD_HOLD     = 8'h03;
  localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

  // A length byte of zero encodes a full 256-byte block.
  function automatic logic [8:0] len_to_count(input logic [7:0] len);
    return (len == 8'h00) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/uart_loader_timeout.sv
// rtl/uart_loader_timeout.sv - inter-byte gap counter; expired flags a stalled frame
module uart_loader_timeout #(
  parameter int TIMEOUT = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  // Saturates at the limit so a stuck enable never wraps back to a "fresh" gap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - decodes sync/cmd/addr/len/payload/checksum frames into memory writes
// and releases the CPU from reset on a verified RUN command.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int         ADDR_W  = 8,
  parameter logic [7:0] SYNC    = DEFAULT_SYNC,
  parameter int         TIMEOUT = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [8:0]        count, count_nxt;
  logic [7:0]        xsum, xsum_nxt;
  logic [7:0]        cmd, cmd_nxt;
  logic              we_nxt, done_nxt, err_nxt, hold_nxt, busy_nxt;
  logic [ADDR_W-1:0] maddr_nxt;
  logic [7:0]        wdata_nxt;
  logic              expired;

  uart_loader_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (rx_valid || (state == S_IDLE)),
    .enable (state != S_IDLE),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      addr      <= '0;
      count     <= '0;
      xsum      <= '0;
      cmd       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      cpu_hold  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      count     <= count_nxt;
      xsum      <= xsum_nxt;
      cmd       <= cmd_nxt;
      mem_we    <= we_nxt;
      mem_addr  <= maddr_nxt;
      mem_wdata <= wdata_nxt;
      load_done <= done_nxt;
      load_err  <= err_nxt;
      cpu_hold  <= hold_nxt;
      busy      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    count_nxt = count;
    xsum_nxt  = xsum;
    cmd_nxt   = cmd;
    we_nxt    = 1'b0;
    maddr_nxt = mem_addr;
    wdata_nxt = mem_wdata;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    hold_nxt  = cpu_hold;

    if (rx_valid) begin
      // The running checksum covers every byte between SYNC and CSUM.
      if (state != S_IDLE && state != S_CSUM) begin
        xsum_nxt = xsum ^ rx_byte;
      end
      unique case (state)
        S_IDLE: begin
          if (rx_byte == SYNC) begin
            state_nxt = S_CMD;
            xsum_nxt  = '0;
          end
        end
        S_CMD: begin
          cmd_nxt = rx_byte;
          if (rx_byte == CMD_WRITE) begin
            state_nxt = S_ADDR;
          end else if (rx_byte == CMD_RUN || rx_byte == CMD_HOLD) begin
            state_nxt = S_CSUM;
          end else begin
            state_nxt = S_IDLE;
            err_nxt   = 1'b1;
          end
        end
        S_ADDR: begin
          addr_nxt  = rx_byte[ADDR_W-1:0];
          state_nxt = S_LEN;
        end
        S_LEN: begin
          count_nxt = len_to_count(rx_byte);
          state_nxt = S_DATA;
        end
        S_DATA: begin
          we_nxt    = 1'b1;
          maddr_nxt = addr;
          wdata_nxt = rx_byte;
          addr_nxt  = addr + ADDR_W'(1);
          count_nxt = count - 9'd1;
          if (count == 9'd1) begin
            state_nxt = S_CSUM;
          end
        end
        S_CSUM: begin
          state_nxt = S_IDLE;
          if (rx_byte == xsum) begin
            done_nxt = 1'b1;
            if (cmd == CMD_RUN) begin
              hold_nxt = 1'b0;
            end else if (cmd == CMD_HOLD) begin
              hold_nxt = 1'b1;
            end
          end else begin
            err_nxt = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if (expired && state != S_IDLE) begin
      state_nxt = S_IDLE;
      err_nxt   = 1'b1;
    end

    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_uart_loader.sv
// tb/tb_uart_loader.sv - directed self-checking bench for uart_loader
module tb_uart_loader;

  localparam int TOUT = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold, busy, load_done, load_err;

  int n_checks = 0;
  int n_fail   = 0;

  int         n_we, n_done, n_err;
  logic [7:0] wr_addr [0:511];
  logic [7:0] wr_data [0:511];

  always #5 clk = ~clk;

  uart_loader #(
    .ADDR_W (8),
    .SYNC   (8'hA5),
    .TIMEOUT(TOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .load_done(load_done),
    .load_err (load_err)
  );

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (n_we < 512) begin
        wr_addr[n_we] = mem_addr;
        wr_data[n_we] = mem_wdata;
      end
      n_we = n_we + 1;
    end
    if (load_done === 1'b1) n_done = n_done + 1;
    if (load_err === 1'b1) n_err = n_err + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Caller sits just after a rising edge; consecutive calls give back-to-back strobes.
  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    n_we = 0;
    n_done = 0;
    n_err = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle(3);
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_hold: got %b expected 1", cpu_hold); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if ({mem_we, load_done, load_err} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b expected 000", {mem_we, load_done, load_err}); end
    reset = 1'b1;
    idle(2);
  endtask

  task automatic test_write();
    clear_mon();
    send(8'hA5);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy_rise: got %b expected 1", busy); end
    send(8'h01); send(8'h10); send(8'h03);
    send(8'h11); send(8'h22); send(8'h33);
    send(8'h12);
    n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL write_done_pulse: got %b expected 1", load_done); end
    idle(3);
    n_checks++; if (n_we !== 3) begin n_fail++; $display("FAIL write_count: got %0d expected 3", n_we); end
    n_checks++; if ({wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], wr_addr[2], wr_data[2]} !== 48'h10_11_11_22_12_33)
      begin n_fail++; $display("FAIL write_pairs: got %h%h %h%h %h%h expected 1011 1122 1233", wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], wr_addr[2], wr_data[2]); end
    n_checks++; if ({n_done, n_err} !== {32'd1, 32'd0}) begin n_fail++; $display("FAIL write_done_err: got done=%0d err=%0d expected 1 0", n_done, n_err); end
    n_checks++; if ({busy, cpu_hold} !== 2'b01) begin n_fail++; $display("FAIL write_idle: got busy/hold=%b expected 01", {busy, cpu_hold}); end
  endtask

  task automatic test_run_hold();
    clear_mon();
    send(8'hA5); send(8'h02);
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL run_before: got %b expected 1", cpu_hold); end
    send(8'h02);
    n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL run_release: got %b expected 0", cpu_hold); end
    idle(2);
    send(8'hA5); send(8'h03); send(8'h03);
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL hold_reassert: got %b expected 1", cpu_hold); end
    idle(2);
    n_checks++; if (n_done !== 2) begin n_fail++; $display("FAIL run_hold_done: got %0d expected 2", n_done); end
  endtask

  task automatic test_wrap();
    clear_mon();
    send(8'hA5); send(8'h01); send(8'hFE); send(8'h03);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'h21);
    idle(2);
    n_checks++; if ({wr_addr[0], wr_addr[1], wr_addr[2]} !== 24'hFE_FF_00) begin n_fail++; $display("FAIL wrap_addr: got %h %h %h expected fe ff 00", wr_addr[0], wr_addr[1], wr_addr[2]); end
    n_checks++; if ({n_we, n_done} !== {32'd3, 32'd1}) begin n_fail++; $display("FAIL wrap_counts: got we=%0d done=%0d expected 3 1", n_we, n_done); end
  endtask

  task automatic test_back_to_back_256();
    clear_mon();
    send(8'hA5); send(8'h01); send(8'h00); send(8'h00);
    for (int i = 0; i < 256; i++) send(8'(i));
    send(8'h01);
    idle(2);
    n_checks++; if (n_we !== 256) begin n_fail++; $display("FAIL len256_count: got %0d expected 256", n_we); end
    n_checks++; if ({wr_addr[255], wr_data[255], wr_addr[128], wr_data[128]} !== 32'hFF_FF_80_80) begin n_fail++; $display("FAIL len256_data: got %h %h %h %h expected ff ff 80 80", wr_addr[255], wr_data[255], wr_addr[128], wr_data[128]); end
    n_checks++; if ({n_done, n_err} !== {32'd1, 32'd0}) begin n_fail++; $display("FAIL len256_done: got done=%0d err=%0d expected 1 0", n_done, n_err); end
  endtask

  task automatic test_errors();
    clear_mon();
    send(8'hA5); send(8'h02); send(8'h00);
    n_checks++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL bad_csum_err: got %b expected 1", load_err); end
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL bad_csum_hold: got %b expected 1", cpu_hold); end
    idle(2);
    send(8'hA5); send(8'h07);
    n_checks++; if ({load_err, busy} !== 2'b10) begin n_fail++; $display("FAIL bad_cmd: got err/busy=%b expected 10", {load_err, busy}); end
    idle(2);
    n_checks++; if ({n_err, n_done} !== {32'd2, 32'd0}) begin n_fail++; $display("FAIL errors_counts: got err=%0d done=%0d expected 2 0", n_err, n_done); end
  endtask

  task automatic test_timeout();
    clear_mon();
    send(8'hA5); send(8'h01); send(8'h20); send(8'h04);
    idle(TOUT - 3);
    n_checks++; if ({n_err, busy} !== {32'd0, 1'b1}) begin n_fail++; $display("FAIL timeout_early: got err=%0d busy=%b expected 0 1", n_err, busy); end
    idle(8);
    n_checks++; if ({n_err, busy, n_we} !== {32'd1, 1'b0, 32'd0}) begin n_fail++; $display("FAIL timeout_fire: got err=%0d busy=%b we=%0d expected 1 0 0", n_err, busy, n_we); end
    send(8'hA5); send(8'h02); send(8'h02);
    n_checks++; if ({load_done, cpu_hold} !== 2'b10) begin n_fail++; $display("FAIL timeout_recover: got done/hold=%b expected 10", {load_done, cpu_hold}); end
    idle(2);
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    send(8'hA5); send(8'h01); send(8'h40); send(8'h04);
    send(8'h55); send(8'h66);
    n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL midreset_pre_we: got %b expected 1", mem_we); end
    reset = 1'b0;
    #1;
    n_checks++; if ({mem_we, cpu_hold, busy} !== 3'b010) begin n_fail++; $display("FAIL midreset_abort: got we/hold/busy=%b expected 010", {mem_we, cpu_hold, busy}); end
    idle(2);
    reset = 1'b1;
    idle(2);
    clear_mon();
    send(8'hA5); send(8'h01); send(8'h50); send(8'h01); send(8'h77); send(8'h27);
    idle(2);
    n_checks++; if ({n_we, n_done, n_err} !== {32'd1, 32'd1, 32'd0}) begin n_fail++; $display("FAIL midreset_reload_counts: got we=%0d done=%0d err=%0d expected 1 1 0", n_we, n_done, n_err); end
    n_checks++; if ({wr_addr[0], wr_data[0]} !== 16'h50_77) begin n_fail++; $display("FAIL midreset_reload_data: got %h %h expected 50 77", wr_addr[0], wr_data[0]); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_write();
    test_run_hold();
    test_wrap();
    test_back_to_back_256();
    test_errors();
    test_timeout();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_loader.md
# uart_loader

Frame-level controller between `uart_sm_rx` and the CPU program memory. Consumes the received byte stream, decodes a sync/command/address/length/payload/checksum frame, and issues single-cycle memory writes. Holds the CPU in reset (`cpu_hold`) until a verified RUN command arrives. A per-byte timeout recovers from truncated frames.

## Interface
Parameters:
- `ADDR_W`, 8: program-memory address width; one address byte, so must be ≤ 8.
- `SYNC`, 8'hA5: frame start byte.
- `TIMEOUT`, 100000: max idle cycles between bytes inside a frame; must be ≥ 2.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset; all state cleared immediately on assertion.
- `rx_byte`  in  8  received byte; valid only when `rx_valid` = 1.
- `rx_valid`  in  1  one-cycle strobe per received byte (driven by the UART RX `byte_end`).
- `mem_we`  out  1  memory write strobe, one cycle per payload byte.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  8  write data.
- `cpu_hold`  out  1  1 = CPU held in reset.
- `busy`  out  1  1 while the FSM is in any state other than IDLE.
- `load_done`  out  1  one-cycle pulse on an accepted frame.
- `load_err`  out  1  one-cycle pulse on a checksum mismatch, unknown command, or timeout.

## Operation
- Commands: 0x01 WRITE = CMD, ADDR, LEN, LEN data bytes, CSUM. 0x02 RUN = CMD, CSUM. 0x03 HOLD = CMD, CSUM.
- CSUM = XOR of every byte after SYNC up to the byte before CSUM. The running XOR clears on SYNC.
- FSM states, advancing only on `rx_valid`:
  - IDLE: byte == SYNC → CMD. Any other byte is ignored.
  - CMD: 0x01 → ADDR; 0x02 or 0x03 → CSUM; any other value → IDLE with `load_err`.
  - ADDR: load the address register → LEN.
  - LEN: load the remaining-count register (9 bits); LEN = 0 means 256 bytes → DATA.
  - DATA: write the byte at the current address, then increment the address modulo 2^ADDR_W (wraps from all-ones to 0). Decrement the count; when the count reaches 0 → CSUM.
  - CSUM: on match, pulse `load_done` and apply the command (RUN: `cpu_hold` ← 0; HOLD: `cpu_hold` ← 1; WRITE: no further action). On mismatch, pulse `load_err`; `cpu_hold` is unchanged and bytes already written stay written. → IDLE.
- Timeout counter:
  - Cleared on every `rx_valid` and held at 0 in IDLE.
  - Outside IDLE it increments each cycle without `rx_valid`.
  - Reaching TIMEOUT-1 → IDLE with `load_err`. If `rx_valid` arrives in that same cycle, the byte wins and no timeout occurs.
- A SYNC value received mid-frame is ordinary data; frames are not resynchronised on it.
- `cpu_hold` changes only on a verified RUN or HOLD, or on reset.

## Timing
- Reset values: `cpu_hold` = 1; all other outputs 0; state IDLE; address, count, XOR and timeout registers 0.
- All outputs are registered.
- `mem_we`, `mem_addr` and `mem_wdata` are valid the cycle after the DATA `rx_valid`.
- `load_done`, `load_err` and the `cpu_hold` update appear the cycle after the CSUM `rx_valid`, or the cycle after the timeout is reached.
- `busy` rises the cycle after SYNC is accepted and falls the cycle after the frame ends.
- Back-to-back `rx_valid` (every cycle) must be handled with no byte loss.
- Reset asserted mid-frame: writes abort immediately and `cpu_hold` returns to 1.

## Structure
- Package `uart_loader_pkg`: FSM state enum (IDLE, CMD, ADDR, LEN, DATA, CSUM), command codes CMD_WRITE/CMD_RUN/CMD_HOLD, and the default SYNC.
- Sub-module `uart_loader_timeout`: the byte-gap counter, with inputs clear and enable and output `expired`. Everything else stays in one FSM module.

## Test plan
- Reset → `cpu_hold` = 1, `busy` = 0. Send A5 01 10 03 11 22 33 CSUM = 0x01^0x10^0x03^0x11^0x22^0x33 → writes (0x10,0x11), (0x11,0x22), (0x12,0x33), then one `load_done` pulse.
- A5 02 02 → `cpu_hold` falls the cycle after the CSUM byte. Then A5 03 03 → `cpu_hold` = 1 again.
- A5 01 FE 03 AA BB CC with the correct CSUM → write addresses FE, FF, 00 (wrap). Also send LEN = 00 with 256 bytes → exactly 256 `mem_we` pulses.
- A5 02 with CSUM 0x00 (wrong) → `load_err` pulse, `cpu_hold` stays 1. A5 07 → `load_err` immediately after the CMD byte, FSM back in IDLE.
- A5 01 20 04 then silence for TIMEOUT cycles → `load_err` pulse, `busy` = 0. The next complete frame is accepted normally.
- Assert `reset` during the DATA phase → `mem_we` = 0 and `cpu_hold` = 1 immediately. A clean frame after release loads correctly.
